// File: rtl/signed_divider_pkg.sv
// Shared types and helpers for the signed divider.
package signed_divider_pkg;

    // Controller states, 3-bit encoding.
    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        UNPACK = 3'd2,
        DIVIDE = 3'd3,
        PACK   = 3'd4,
        PUT_Z  = 3'd5
    } state_e;

    // Step counter width: wide enough to hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/signed_divider_magnitude.sv
// WIDTH-bit conditional two's-complement negate (purely combinational).
// Used both to take operand magnitudes and to re-apply result signs.
module signed_divider_magnitude #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);

    // Negate when asked; MIN maps onto itself, which is its unsigned magnitude.
    always_comb begin
        dout = neg ? ({WIDTH{1'b0}} - din) : din;
    end

endmodule

// File: rtl/signed_divider.sv
// Multi-cycle signed divider: strobe/ack operand intake, restoring divide on
// unsigned magnitudes, sign fix-up, then a held result until acknowledged.
module signed_divider
    import signed_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_a,
    input  logic             input_a_stb,
    output logic             input_a_ack,
    input  logic [WIDTH-1:0] input_b,
    input  logic             input_b_stb,
    output logic             input_b_ack,
    output logic [WIDTH-1:0] output_z,
    output logic [WIDTH-1:0] output_r,
    output logic             output_z_stb,
    input  logic             output_z_ack
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, div_q, div_d;
    logic [WIDTH-1:0] z_q, z_d, r_q, r_d;
    logic             sign_q_q, sign_q_d, sign_r_q, sign_r_d;
    logic             a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] m0_in, m0_out, m1_in, m1_out;
    logic             m0_neg, m1_neg;
    logic [WIDTH-1:0] rem_shift, rem_sub;
    logic             rem_ge;

    // The two negators serve the operands in UNPACK and the results in PACK.
    always_comb begin
        m0_in  = a_q;
        m0_neg = a_q[WIDTH-1];
        m1_in  = b_q;
        m1_neg = b_q[WIDTH-1];
        if (state_q == PACK) begin
            m0_in  = quo_q;
            m0_neg = sign_q_q;
            m1_in  = rem_q;
            m1_neg = sign_r_q;
        end
    end

    signed_divider_magnitude #(.WIDTH(WIDTH)) u_mag_zq (
        .din  (m0_in),
        .neg  (m0_neg),
        .dout (m0_out)
    );

    signed_divider_magnitude #(.WIDTH(WIDTH)) u_mag_rb (
        .din  (m1_in),
        .neg  (m1_neg),
        .dout (m1_out)
    );

    // One restoring step. rem stays below |b| <= 2^(WIDTH-1), so the shifted
    // partial remainder always fits in WIDTH bits.
    always_comb begin
        rem_shift = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        rem_ge    = (rem_shift >= div_q);
        rem_sub   = rem_shift - div_q;
    end

    // Next-state, handshake and datapath control.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        div_d    = div_q;
        z_d      = z_q;
        r_d      = r_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        a_ack_d  = a_ack_q;
        b_ack_d  = b_ack_q;
        z_stb_d  = z_stb_q;
        cnt_d    = cnt_q;
        case (state_q)
            GET_A: begin
                if (a_ack_q && input_a_stb) begin
                    a_d     = input_a;
                    a_ack_d = 1'b0;
                    b_ack_d = 1'b1;
                    state_d = GET_B;
                end else begin
                    a_ack_d = 1'b1;
                end
            end
            GET_B: begin
                if (b_ack_q && input_b_stb) begin
                    b_d     = input_b;
                    b_ack_d = 1'b0;
                    state_d = UNPACK;
                end else begin
                    b_ack_d = 1'b1;
                end
            end
            UNPACK: begin
                quo_d    = m0_out;
                div_d    = m1_out;
                sign_q_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                sign_r_d = a_q[WIDTH-1];
                rem_d    = '0;
                cnt_d    = '0;
                state_d  = DIVIDE;
            end
            DIVIDE: begin
                quo_d = {quo_q[WIDTH-2:0], rem_ge};
                rem_d = rem_ge ? rem_sub : rem_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = PACK;
                end
            end
            PACK: begin
                // Divide by zero ran the full step count; override its result.
                if (div_q == '0) begin
                    z_d = '1;
                    r_d = a_q;
                end else begin
                    z_d = m0_out;
                    r_d = m1_out;
                end
                z_stb_d = 1'b1;
                state_d = PUT_Z;
            end
            PUT_Z: begin
                if (output_z_ack) begin
                    z_stb_d = 1'b0;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    // State and datapath registers; reset overrides any same-cycle transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= GET_A;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            z_q      <= '0;
            r_q      <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            z_stb_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            z_q      <= z_d;
            r_q      <= r_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            a_ack_q  <= a_ack_d;
            b_ack_q  <= b_ack_d;
            z_stb_q  <= z_stb_d;
            cnt_q    <= cnt_d;
        end
    end

    assign input_a_ack  = a_ack_q;
    assign input_b_ack  = b_ack_q;
    assign output_z     = z_q;
    assign output_r     = r_q;
    assign output_z_stb = z_stb_q;

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider: directed table, hand-written
// handshake/reset sequences, and random operands against an arithmetic model.
module tb_signed_divider;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] input_a, input_b;
    logic         input_a_stb, input_b_stb;
    logic         input_a_ack, input_b_ack;
    logic [W-1:0] output_z, output_r;
    logic         output_z_stb, output_z_ack;

    int nvec = 0;
    int errs = 0;
    int cyc  = 0;

    signed_divider #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .output_z     (output_z),
        .output_r     (output_r),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] z;
        logic [W-1:0] r;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: truncating signed division in wide arithmetic, remainder
    // carries the dividend's sign; divide by zero gives all-ones and r=a.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] z, output logic [W-1:0] r);
        longint la, lb, q, m;
        if (b == '0) begin
            z = '1;
            r = a;
        end else begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            q  = la / lb;
            m  = la % lb;
            z  = q[W-1:0];
            r  = m[W-1:0];
        end
    endtask

    // Offer a then b; returns at a falling edge with t0 = cycle of the b transfer.
    task automatic send_ab(input logic [W-1:0] a, input logic [W-1:0] b, output int t0);
        int n;
        input_a = a;
        input_a_stb = 1'b1;
        n = 0;
        while (input_a_ack !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("timeout_a_ack", {31'd0, input_a_ack}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        input_a_stb = 1'b0;
        input_b = b;
        input_b_stb = 1'b1;
        n = 0;
        while (input_b_ack !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("timeout_b_ack", {31'd0, input_b_ack}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        input_b_stb = 1'b0;
        t0 = cyc;
    endtask

    // Wait for the result strobe; optionally acknowledge it for one cycle.
    task automatic get_z(input int t0, input bit do_ack,
                         output logic [W-1:0] z, output logic [W-1:0] r, output int lat);
        int n;
        n = 0;
        while (output_z_stb !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("timeout_z_stb", {31'd0, output_z_stb}, 32'd1);
        lat = cyc - t0;
        z = output_z;
        r = output_r;
        if (do_ack) begin
            output_z_ack = 1'b1;
            @(negedge clk);
            output_z_ack = 1'b0;
        end
    endtask

    task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] ez, input logic [W-1:0] er);
        int t0, lat;
        logic [W-1:0] z, r;
        send_ab(a, b, t0);
        get_z(t0, 1'b1, z, r, lat);
        chk({name, "_z"}, z, ez);
        chk({name, "_r"}, r, er);
        chk({name, "_lat"}, lat, LAT);
    endtask

    initial begin
        int t0, lat, bad;
        logic [W-1:0] z, r, ez, er, a, b, hz, hr;

        tbl[0] = '{32'd7,          32'd2,          32'd3,          32'd1};
        tbl[1] = '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
        tbl[2] = '{32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
        tbl[3] = '{32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF};
        tbl[4] = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5};
        tbl[5] = '{32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB};
        tbl[6] = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
        tbl[7] = '{32'h80000000,   32'd1,          32'h80000000,   32'd0};
        tbl[8] = '{32'd0,          32'hFFFFFFF3,   32'd0,          32'd0};
        tbl[9] = '{32'd100,        32'h80000000,   32'd0,          32'd100};

        rst = 1'b1;
        input_a = '0;
        input_b = '0;
        input_a_stb = 1'b0;
        input_b_stb = 1'b0;
        output_z_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_ack", {31'd0, input_a_ack}, 32'd0);
        chk("rst_b_ack", {31'd0, input_b_ack}, 32'd0);
        chk("rst_stb",   {31'd0, output_z_stb}, 32'd0);
        chk("rst_z",     output_z, 32'd0);
        chk("rst_r",     output_r, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_a_ack", {31'd0, input_a_ack}, 32'd1);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].z, tbl[i].r);
        end

        // Backpressure: result held steady and no new intake while unacknowledged.
        send_ab(32'd1000, 32'd7, t0);
        get_z(t0, 1'b0, hz, hr, lat);
        chk("bp_lat", lat, LAT);
        chk("bp_z", hz, 32'd142);
        chk("bp_r", hr, 32'd6);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (output_z_stb !== 1'b1 || output_z !== hz || output_r !== hr || input_a_ack !== 1'b0)
                bad++;
        end
        chk("bp_hold_bad_cycles", bad, 0);
        output_z_ack = 1'b1;
        @(negedge clk);
        output_z_ack = 1'b0;
        chk("bp_stb_drop", {31'd0, output_z_stb}, 32'd0);
        chk("bp_a_ack_still_low", {31'd0, input_a_ack}, 32'd0);
        @(negedge clk);
        chk("bp_a_ack_rise", {31'd0, input_a_ack}, 32'd1);

        // Early ack held high before and through the strobe has no side effect.
        output_z_ack = 1'b1;
        run_check("early_ack", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);
        output_z_ack = 1'b0;

        // Reset in the middle of DIVIDE abandons the operation.
        send_ab(32'd12345, 32'd11, t0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_stb", {31'd0, output_z_stb}, 32'd0);
        chk("midrst_z", output_z, 32'd0);
        chk("midrst_r", output_r, 32'd0);
        chk("midrst_a_ack", {31'd0, input_a_ack}, 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (output_z_stb !== 1'b0) bad++;
        end
        chk("midrst_no_stb", bad, 0);
        run_check("after_rst", 32'd100, 32'd7, 32'd14, 32'd2);

        // Random operands, biased toward small magnitudes, zero and extremes.
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = $urandom_range(0, 15) - 8;
                1: a = $urandom_range(0, 255) - 128;
                2: b = '0;
                3: a = 32'h80000000;
                default: ;
            endcase
            ref_div(a, b, ez, er);
            run_check($sformatf("rnd%0d", i), a, b, ez, er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
